hub75_simple_turn_on: RTL and testbench



---
 rtl/hub75_simple_turn_on.sv | 153 +++++++++++++++
 tb/tb_hub75_simple_turn_on.sv | 121 ++++++++++++
 2 files changed

// File: rtl/hub75_simple_turn_on.sv
// HUB75 bring-up driver: shifts a fixed colour (or a test pattern when
// SIMPLE_TURN_ON_PATTERN_EN is defined) into every row pair, latches it, and displays it.
module hub75_simple_turn_on #(
    parameter int         COLS      = 32,
    parameter int         ON_CYCLES = 64,
    parameter logic [2:0] COLOR_TOP = 3'b111,
    parameter logic [2:0] COLOR_BOT = 3'b111
) (
    input  logic clk,
    input  logic resetn,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic E,
    output logic R0,
    output logic G0,
    output logic B0,
    output logic R1,
    output logic G1,
    output logic B1,
    output logic LATCH,
    output logic nOE,
    output logic S_CLK,
    output logic LEDS
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int OW = $clog2(ON_CYCLES + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [OW-1:0] ON_LAST  = OW'(ON_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SHIFT,
        ST_BLANK,
        ST_LATCH,
        ST_SHOW
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] col_reg, col_next;
    logic          phase_reg, phase_next;
    logic [4:0]    row_reg, row_next;
    logic [OW-1:0] on_cnt_reg, on_cnt_next;

    logic [4:0]    addr_reg, addr_next;
    logic [5:0]    rgb_reg, rgb_next;
    logic          latch_reg, latch_next;
    logic          noe_reg, noe_next;
    logic          sclk_reg, sclk_next;
    logic          leds_reg, leds_next;

    logic [5:0]    shift_rgb;

`ifdef SIMPLE_TURN_ON_PATTERN_EN
    // Zero-extend so narrow COLS settings still have col bits 1 and 2.
    logic [CW+2:0] col_wide;
    assign col_wide  = {3'b000, col_reg};
    assign shift_rgb = {col_wide[0], col_wide[1], col_wide[2],
                        row_reg[0], row_reg[1], row_reg[2]};
`else
    assign shift_rgb = {COLOR_TOP, COLOR_BOT};
`endif

    // Outputs are registered from the current state, so each output
    // register shows the behaviour of the state that was just left.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_reg  <= ST_SHIFT;
            col_reg    <= '0;
            phase_reg  <= 1'b0;
            row_reg    <= '0;
            on_cnt_reg <= '0;
            addr_reg   <= '0;
            rgb_reg    <= '0;
            latch_reg  <= 1'b0;
            noe_reg    <= 1'b1;
            sclk_reg   <= 1'b0;
            leds_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            col_reg    <= col_next;
            phase_reg  <= phase_next;
            row_reg    <= row_next;
            on_cnt_reg <= on_cnt_next;
            addr_reg   <= addr_next;
            rgb_reg    <= rgb_next;
            latch_reg  <= latch_next;
            noe_reg    <= noe_next;
            sclk_reg   <= sclk_next;
            leds_reg   <= leds_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        col_next    = col_reg;
        phase_next  = phase_reg;
        row_next    = row_reg;
        on_cnt_next = on_cnt_reg;
        addr_next   = addr_reg;
        rgb_next    = rgb_reg;
        latch_next  = 1'b0;
        noe_next    = 1'b1;
        sclk_next   = 1'b0;
        // Sticky status: set the cycle after the first latch pulse.
        leds_next   = leds_reg | latch_reg;

        case (state_reg)
            ST_SHIFT: begin
                sclk_next  = phase_reg;
                phase_next = ~phase_reg;
                if (!phase_reg) begin
                    rgb_next = shift_rgb;
                end else if (col_reg == COL_LAST) begin
                    state_next = ST_BLANK;
                end else begin
                    col_next = col_reg + 1'b1;
                end
            end
            ST_BLANK: begin
                rgb_next   = '0;
                addr_next  = row_reg;
                state_next = ST_LATCH;
            end
            ST_LATCH: begin
                latch_next  = 1'b1;
                on_cnt_next = '0;
                state_next  = ST_SHOW;
            end
            ST_SHOW: begin
                noe_next = 1'b0;
                if (on_cnt_reg == ON_LAST) begin
                    row_next   = row_reg + 1'b1;
                    col_next   = '0;
                    phase_next = 1'b0;
                    state_next = ST_SHIFT;
                end else begin
                    on_cnt_next = on_cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_SHIFT;
        endcase
    end

    assign {E, D, C, B, A}          = addr_reg;
    assign {R0, G0, B0, R1, G1, B1} = rgb_reg;
    assign LATCH = latch_reg;
    assign nOE   = noe_reg;
    assign S_CLK = sclk_reg;
    assign LEDS  = leds_reg;

endmodule

// File: tb/tb_hub75_simple_turn_on.sv
// Directed bench for hub75_simple_turn_on: per-cycle expected output words are
// queued from a timing model and compared against the registered panel outputs.
module tb_hub75_simple_turn_on;

    localparam int COLS = 32;
    localparam int ON   = 64;
    localparam int PER  = 2 * COLS + 2 + ON;
    localparam logic [14:0] RESET_WORD = {5'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic A, B, C, D, E, R0, G0, B0, R1, G1, B1, LATCH, nOE, S_CLK, LEDS;

    int vectors = 0;
    int miscompares = 0;
    logic [14:0] sb[$];

    always #5 clk = ~clk;

    hub75_simple_turn_on #(
        .COLS(COLS), .ON_CYCLES(ON), .COLOR_TOP(3'b111), .COLOR_BOT(3'b111)
    ) dut (
        .clk(clk), .resetn(resetn),
        .A(A), .B(B), .C(C), .D(D), .E(E),
        .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
        .LATCH(LATCH), .nOE(nOE), .S_CLK(S_CLK), .LEDS(LEDS)
    );

    // Word layout: {addr[4:0], R0,G0,B0,R1,G1,B1, LATCH, nOE, S_CLK, LEDS}
    function automatic logic [14:0] model(input int k);
        int r, t, c;
        logic [4:0] addr, rr, cb;
        logic [5:0] rgb;
        logic lat, noe, sclk, leds;
        r    = k / PER;
        t    = k % PER;
        rr   = 5'(r % 32);
        rgb  = '0;
        lat  = 1'b0;
        noe  = 1'b1;
        sclk = 1'b0;
        leds = (k >= 2 * COLS + 2);
        if (t < 2 * COLS) begin
            addr = (r == 0) ? 5'd0 : 5'((r - 1) % 32);
            sclk = t[0];
            c    = t / 2;
            cb   = c[4:0];
`ifdef SIMPLE_TURN_ON_PATTERN_EN
            rgb = {cb[0], cb[1], cb[2], rr[0], rr[1], rr[2]};
`else
            rgb = 6'b111111;
`endif
        end else begin
            addr = rr;
            if (t == 2 * COLS + 1) lat = 1'b1;
            else if (t > 2 * COLS + 1) noe = 1'b0;
        end
        return {addr, rgb, lat, noe, sclk, leds};
    endfunction

    function automatic logic [14:0] observed();
        return {E, D, C, B, A, R0, G0, B0, R1, G1, B1, LATCH, nOE, S_CLK, LEDS};
    endfunction

    task automatic tick(input logic [14:0] exp_word, input string tag, input int k);
        logic [14:0] want, got;
        sb.push_back(exp_word);
        @(posedge clk);
        @(negedge clk);
        got  = observed();
        want = sb.pop_front();
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s cycle %0d observed=%h expected=%h", tag, k, got, want);
        end
        vectors++;
        assert (!(LATCH === 1'b1 && nOE === 1'b0)) else begin
            miscompares++;
            $error("FAIL latch_during_show cycle %0d observed LATCH=%b nOE=%b expected not both active", k, LATCH, nOE);
        end
    endtask

    initial begin
        int edges;
        logic prev_sclk;

        // Reset held: outputs at reset values every cycle.
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) tick(RESET_WORD, "reset_hold", i);

        // Run 32 full rows plus part of the next row, stopping mid-SHOW.
        resetn = 1'b0;
        edges = 0;
        prev_sclk = 1'b0;
        for (int k = 0; k < 32 * PER + 100; k++) begin
            tick(model(k), "run", k);
            if (k < 70) begin
                if (S_CLK === 1'b1 && prev_sclk === 1'b0) edges++;
                prev_sclk = S_CLK;
            end
        end
        vectors++;
        assert (edges == 32) else begin
            miscompares++;
            $error("FAIL sclk_edges_row0 observed=%0d expected=%0d", edges, 32);
        end

        // Reset asserted during SHOW: outputs return to reset values next cycle.
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) tick(RESET_WORD, "reset_mid_show", i);

        // Timing restarts from cycle 0 after release.
        resetn = 1'b0;
        for (int k = 0; k < PER + 70; k++) tick(model(k), "restart", k);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
